ir_transmit: RTL and testbench



---
 rtl/ir_transmit.sv | 120 ++++++++++++
 tb/tb_ir_transmit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_transmit.sv
// rtl/ir_transmit.sv - pulse-width IR frame transmitter (lead, 16 data bits, sync, stop, idle gap)
module ir_transmit #(
  parameter int         CLK_DIV   = 6250,
  parameter logic [7:0] ADDR      = 8'h00,
  parameter int         T_LEAD    = 24,
  parameter int         T_BIT_LOW = 4,
  parameter int         T_ZERO    = 12,
  parameter int         T_ONE     = 20,
  parameter int         T_SYNC    = 28,
  parameter int         T_GAP     = 2100
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       remote_out
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PH_W  = 16;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LEAD_LOW  = 4'd1,
    S_LEAD_HIGH = 4'd2,
    S_BIT_LOW   = 4'd3,
    S_BIT_HIGH  = 4'd4,
    S_END_LOW   = 4'd5,
    S_SYNC_HIGH = 4'd6,
    S_STOP_LOW  = 4'd7,
    S_GAP       = 4'd8
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [DIV_W-1:0]  div_cnt;
  logic [PH_W-1:0]   phase_cnt;
  logic [PH_W-1:0]   phase_len;
  logic [15:0]       frame;
  logic [3:0]        bit_idx;
  logic              tick;
  logic              phase_done;
  logic              accept;
  logic              cur_bit;

  assign tick       = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign tx_ready   = (state == S_IDLE);
  assign accept     = tx_valid && tx_ready;
  assign cur_bit    = frame[bit_idx];
  assign phase_done = tick && (phase_cnt == (phase_len - PH_W'(1)));
  assign tx_done    = (state == S_STOP_LOW) && phase_done;

  // Line level belonging to each state; unknown encodings idle high.
  function automatic logic line_level(input state_t s);
    case (s)
      S_LEAD_LOW, S_BIT_LOW, S_END_LOW, S_STOP_LOW: line_level = 1'b0;
      default:                                      line_level = 1'b1;
    endcase
  endfunction

  always_comb begin
    phase_len = PH_W'(T_BIT_LOW);
    case (state)
      S_LEAD_LOW, S_LEAD_HIGH: phase_len = PH_W'(T_LEAD);
      S_BIT_HIGH:              phase_len = cur_bit ? PH_W'(T_ONE) : PH_W'(T_ZERO);
      S_SYNC_HIGH:             phase_len = PH_W'(T_SYNC);
      S_GAP:                   phase_len = PH_W'(T_GAP);
      default:                 phase_len = PH_W'(T_BIT_LOW);
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (accept)     state_next = S_LEAD_LOW;
      S_LEAD_LOW:  if (phase_done) state_next = S_LEAD_HIGH;
      S_LEAD_HIGH: if (phase_done) state_next = S_BIT_LOW;
      S_BIT_LOW:   if (phase_done) state_next = S_BIT_HIGH;
      S_BIT_HIGH:  if (phase_done) state_next = (bit_idx == 4'd0) ? S_END_LOW : S_BIT_LOW;
      S_END_LOW:   if (phase_done) state_next = S_SYNC_HIGH;
      S_SYNC_HIGH: if (phase_done) state_next = S_STOP_LOW;
      S_STOP_LOW:  if (phase_done) state_next = S_GAP;
      S_GAP:       if (phase_done) state_next = S_IDLE;
      default:                     state_next = S_IDLE;
    endcase
  end

  // remote_out is registered from the next state so the level flips on the same edge as the state.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= S_IDLE;
      div_cnt    <= '0;
      phase_cnt  <= '0;
      bit_idx    <= '0;
      frame      <= '0;
      remote_out <= 1'b1;
    end else begin
      state      <= state_next;
      remote_out <= line_level(state_next);
      if (accept) begin
        div_cnt   <= '0;
        phase_cnt <= '0;
        frame     <= {ADDR, tx_data};
      end else begin
        div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
        if (state == S_IDLE || phase_done)
          phase_cnt <= '0;
        else if (tick)
          phase_cnt <= phase_cnt + PH_W'(1);
      end
      if (state == S_LEAD_HIGH && phase_done)
        bit_idx <= 4'd15;
      else if (state == S_BIT_HIGH && phase_done && bit_idx != 4'd0)
        bit_idx <= bit_idx - 4'd1;
    end
  end

endmodule

// File: tb/tb_ir_transmit.sv
// tb/tb_ir_transmit.sv - two ir_transmit instances (ADDR 00 / FF) against a tick-level frame model
module tb_ir_transmit;

  localparam int CD     = 10;
  localparam int T_LEAD = 24;
  localparam int T_BL   = 4;
  localparam int T_ZERO = 12;
  localparam int T_ONE  = 20;
  localparam int T_SYNC = 28;
  localparam int T_GAP  = 2100;

  logic       clk = 1'b0;
  logic       rst;
  logic       vld;
  logic [7:0] dat;
  wire  [1:0] rdy_v;
  wire  [1:0] done_v;
  wire  [1:0] out_v;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  ir_transmit #(.CLK_DIV(CD), .ADDR(8'h00)) u0 (
    .sys_clk(clk), .sys_rst(rst), .tx_valid(vld), .tx_data(dat),
    .tx_ready(rdy_v[0]), .tx_done(done_v[0]), .remote_out(out_v[0]));

  ir_transmit #(.CLK_DIV(CD), .ADDR(8'hFF)) u1 (
    .sys_clk(clk), .sys_rst(rst), .tx_valid(vld), .tx_data(dat),
    .tx_ready(rdy_v[1]), .tx_done(done_v[1]), .remote_out(out_v[1]));

  function automatic logic [7:0] addr_of(input int i);
    return (i == 0) ? 8'h00 : 8'hFF;
  endfunction

  function automatic int frame_ticks(input logic [15:0] w);
    int n;
    n = 2 * T_LEAD + 18 * T_BL + T_SYNC;
    for (int b = 0; b < 16; b++) n += w[b] ? T_ONE : T_ZERO;
    return n;
  endfunction

  // Walk the frame phase by phase to find the line level at a tick offset.
  function automatic logic level_at(input logic [15:0] w, input int tk_in);
    int tk;
    int h;
    tk = tk_in;
    if (tk < T_LEAD) return 1'b0;
    tk -= T_LEAD;
    if (tk < T_LEAD) return 1'b1;
    tk -= T_LEAD;
    for (int b = 15; b >= 0; b--) begin
      if (tk < T_BL) return 1'b0;
      tk -= T_BL;
      h = w[b] ? T_ONE : T_ZERO;
      if (tk < h) return 1'b1;
      tk -= h;
    end
    if (tk < T_BL) return 1'b0;
    tk -= T_BL;
    if (tk < T_SYNC) return 1'b1;
    tk -= T_SYNC;
    if (tk < T_BL) return 1'b0;
    return 1'b1;
  endfunction

  // Reference model: per instance, busy flag plus cycle offset since accept.
  bit          m_init = 1'b0;
  bit          m_busy  [2];
  int          m_t     [2];
  int          m_fcyc  [2];
  int          m_total [2];
  logic [15:0] m_w     [2];

  always @(posedge clk) begin
    if (rst) m_init <= 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_busy[i] <= 1'b0;
      end else if (!m_busy[i]) begin
        if (vld) begin
          m_busy[i]  <= 1'b1;
          m_t[i]     <= 0;
          m_w[i]     <= {addr_of(i), dat};
          m_fcyc[i]  <= frame_ticks({addr_of(i), dat}) * CD;
          m_total[i] <= (frame_ticks({addr_of(i), dat}) + T_GAP) * CD;
        end
      end else if (m_t[i] + 1 >= m_total[i]) begin
        m_busy[i] <= 1'b0;
      end else begin
        m_t[i] <= m_t[i] + 1;
      end
    end
  end

  // Event log taken from DUT handshakes, used for the literal timing checks.
  int cyc = 0;
  int n_acc  [2] = '{0, 0};
  int n_done [2] = '{0, 0};
  int acc_log  [2][8];
  int done_log [2][8];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (rdy_v[i] === 1'b1 && vld === 1'b1 && rst === 1'b0 && n_acc[i] < 8) begin
        acc_log[i][n_acc[i]] <= cyc;
        n_acc[i] <= n_acc[i] + 1;
      end
      if (done_v[i] === 1'b1 && n_done[i] < 8) begin
        done_log[i][n_done[i]] <= cyc;
        n_done[i] <= n_done[i] + 1;
      end
    end
  end

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_bit(input string name, input int i, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] actual=%0b expected=%0b t=%0t", name, i, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    logic eo, er, ed;
    for (int i = 0; i < 2; i++) begin
      if (!m_busy[i]) begin
        eo = 1'b1; er = 1'b1; ed = 1'b0;
      end else begin
        eo = level_at(m_w[i], m_t[i] / CD);
        er = 1'b0;
        ed = (m_t[i] == m_fcyc[i] - 1);
      end
      chk_bit("remote_out", i, out_v[i], eo);
      chk_bit("tx_ready", i, rdy_v[i], er);
      chk_bit("tx_done", i, done_v[i], ed);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int k;
    logic [7:0] rd;
    rst = 1'b1;
    vld = 1'b0;
    dat = 8'h00;
    fork
      forever begin
        @(negedge clk);
        if (m_init) compare_cycle();
      end
    join_none

    repeat (3) step();
    chk_int("reset_out", int'(out_v), 3);
    chk_int("reset_ready", int'(rdy_v), 3);
    chk_int("reset_done", int'(done_v), 0);
    rst = 1'b0;
    step();
    chk_int("post_reset_out", int'(out_v), 3);
    chk_int("post_reset_ready", int'(rdy_v), 3);

    // Frame A5, with requests during the frame and the gap that must be dropped.
    vld = 1'b1; dat = 8'hA5;
    step();
    vld = 1'b0;
    repeat (1000) step();
    vld = 1'b1; dat = 8'h3C;
    step();
    vld = 1'b0;
    repeat (6000) step();
    vld = 1'b1; dat = 8'h3C;
    step();
    vld = 1'b0;
    repeat (17000) step();

    // Held request for 00 must be taken on the first idle cycle of each instance.
    vld = 1'b1; dat = 8'h00;
    k = 0;
    while (!(n_acc[0] >= 2 && n_acc[1] >= 2) && k < 5000) begin step(); k++; end
    vld = 1'b0;
    chk_int("accept_00_timeout", int'(k < 5000), 1);
    k = 0;
    while (!(n_done[0] >= 2 && n_done[1] >= 2) && k < 6000) begin step(); k++; end
    chk_int("done_00_timeout", int'(k < 6000), 1);
    k = 0;
    while (rdy_v !== 2'b11 && k < 25000) begin step(); k++; end
    chk_int("ready_00_timeout", int'(k < 25000), 1);

    chk_int("u0_a5_done_cycles", done_log[0][0] - acc_log[0][0], 3720);
    chk_int("u1_a5_done_cycles", done_log[1][0] - acc_log[1][0], 4360);
    chk_int("u0_gap_to_accept", acc_log[0][1] - done_log[0][0], 21001);
    chk_int("u1_gap_to_accept", acc_log[1][1] - done_log[1][0], 21001);
    chk_int("u0_00_done_cycles", done_log[0][1] - acc_log[0][1], 3400);
    chk_int("u1_00_done_cycles", done_log[1][1] - acc_log[1][1], 4040);
    chk_int("u0_accept_count", n_acc[0], 2);
    chk_int("u1_accept_count", n_acc[1], 2);

    // Frame FF on u0 is cut by reset in the high phase of bit 7 (ticks 180..199).
    vld = 1'b1; dat = 8'hFF;
    step();
    vld = 1'b0;
    repeat (1900) step();
    rst = 1'b1;
    step();
    chk_int("midreset_out", int'(out_v[0]), 1);
    chk_int("midreset_ready", int'(rdy_v[0]), 1);
    rst = 1'b0;
    step();
    chk_int("midreset_no_done", n_done[0], 2);

    // Clean frame with random data right after reset.
    rd = 8'($urandom_range(0, 255));
    vld = 1'b1; dat = rd;
    step();
    vld = 1'b0;
    k = 0;
    while (!(n_done[0] >= 3 && n_done[1] >= 3) && k < 6000) begin step(); k++; end
    chk_int("done_rand_timeout", int'(k < 6000), 1);
    chk_int("u0_rand_done_cycles", done_log[0][2] - acc_log[0][3], frame_ticks({8'h00, rd}) * CD);
    chk_int("u1_rand_done_cycles", done_log[1][2] - acc_log[1][3], frame_ticks({8'hFF, rd}) * CD);
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
